// File: rtl/multi_gate_pkg.sv
// Shared types and helpers for the masked multi-operand gate pipeline.
package multi_gate_pkg;

  typedef enum logic [2:0] {
    MODE_OR   = 3'd0,
    MODE_AND  = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NOR  = 3'd3,
    MODE_NAND = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_ILL6 = 3'd6,
    MODE_ILL7 = 3'd7
  } mode_e;

  // Per-bit identity of each base operation; replicate to operand width.
  localparam logic IDENT_OR_XOR = 1'b0;
  localparam logic IDENT_AND    = 1'b1;

  function automatic logic mode_is_legal(input mode_e m);
    return (m != MODE_ILL6) && (m != MODE_ILL7);
  endfunction

endpackage

// File: rtl/multi_gate_pipe_gate_reduce.sv
// Combinational masked reduction of NUM_IN operands under a selectable gate.
module gate_reduce
  import multi_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] operands,
  input  logic [NUM_IN-1:0]       mask,
  input  mode_e                   mode,
  output logic [WIDTH-1:0]        result,
  output logic                    err
);

  logic [WIDTH-1:0] acc_or;
  logic [WIDTH-1:0] acc_and;
  logic [WIDTH-1:0] acc_xor;

  always_comb begin
    acc_or  = {WIDTH{IDENT_OR_XOR}};
    acc_and = {WIDTH{IDENT_AND}};
    acc_xor = {WIDTH{IDENT_OR_XOR}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (mask[k]) begin
        acc_or  = acc_or  | operands[k*WIDTH +: WIDTH];
        acc_and = acc_and & operands[k*WIDTH +: WIDTH];
        acc_xor = acc_xor ^ operands[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    result = '0;
    err    = !mode_is_legal(mode);
    case (mode)
      MODE_OR:   result = acc_or;
      MODE_AND:  result = acc_and;
      MODE_XOR:  result = acc_xor;
      MODE_NOR:  result = ~acc_or;
      MODE_NAND: result = ~acc_and;
      MODE_XNOR: result = ~acc_xor;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/multi_gate_pipe.sv
// Two-stage valid/ready pipeline: S1 captures operands, S2 holds the reduced result.
module multi_gate_pipe
  import multi_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic [2:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_any,
  output logic                    out_all,
  output logic                    out_err,
  output logic [CNT_W-1:0]        out_count
);

  logic                    s1_valid;
  logic [NUM_IN*WIDTH-1:0] s1_data;
  logic [NUM_IN-1:0]       s1_mask;
  mode_e                   s1_mode;

  logic                    s1_load;
  logic                    s2_load;
  logic [WIDTH-1:0]        red_result;
  logic                    red_err;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mask  <= '0;
      s1_mode  <= MODE_OR;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mask <= in_mask;
        s1_mode <= mode_e'(in_mode);
      end
    end
  end

  gate_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .operands (s1_data),
    .mask     (s1_mask),
    .mode     (s1_mode),
    .result   (red_result),
    .err      (red_err)
  );

  // Result fields are forced to zero whenever the stage is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_any   <= 1'b0;
      out_all   <= 1'b0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      out_data  <= s1_valid ? red_result : '0;
      out_any   <= s1_valid && (|red_result);
      out_all   <= s1_valid && (&red_result);
      out_err   <= s1_valid && red_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_gate_pipe.sv
// Scoreboard bench for multi_gate_pipe (WIDTH=8, NUM_IN=4, CNT_W=4).
module tb_multi_gate_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_mask;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_any;
  logic        out_all;
  logic        out_err;
  logic [3:0]  out_count;

  typedef struct packed {
    logic [7:0] d;
    logic       any;
    logic       all;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] cnt_m;
  int         n_chk  = 0;
  int         n_pass = 0;
  logic       rnd_done;

  multi_gate_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_any   (out_any),
    .out_all   (out_all),
    .out_err   (out_err),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic [3:0] m, input logic [2:0] md);
    logic [7:0] o, a, x, r;
    exp_t e;
    o = 8'h00; a = 8'hFF; x = 8'h00;
    for (int k = 0; k < 4; k++)
      if (m[k]) begin
        o = o | d[k*8 +: 8];
        a = a & d[k*8 +: 8];
        x = x ^ d[k*8 +: 8];
      end
    e.err = 1'b0;
    case (md)
      3'd0: r = o;
      3'd1: r = a;
      3'd2: r = x;
      3'd3: r = ~o;
      3'd4: r = ~a;
      3'd5: r = ~x;
      default: begin r = 8'h00; e.err = 1'b1; end
    endcase
    e.d   = r;
    e.any = !e.err && (r != 8'h00);
    e.all = !e.err && (r == 8'hFF);
    return e;
  endfunction

  // Monitor: compare the head of the queue every valid cycle, pop on transfer.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      cnt_m = 4'd0;
    end else begin
      chk("count", {28'd0, out_count}, {28'd0, cnt_m});
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("data", {24'd0, out_data}, {24'd0, sbq[0].d});
          chk("any",  {31'd0, out_any},  {31'd0, sbq[0].any});
          chk("all",  {31'd0, out_all},  {31'd0, sbq[0].all});
          chk("err",  {31'd0, out_err},  {31'd0, sbq[0].err});
          if (out_ready) begin
            void'(sbq.pop_front());
            cnt_m = cnt_m + 4'd1;
          end
        end
      end else begin
        chk("idle_zero", {21'd0, out_data, out_any, out_all, out_err}, 32'd0);
      end
      if (in_valid && in_ready) sbq.push_back(model(in_data, in_mask, in_mode));
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] m, input logic [2:0] md);
    int   waited;
    logic acc;
    in_valid = 1'b1; in_data = d; in_mask = m; in_mode = md;
    waited = 0;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 200);
    if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_count", {28'd0, out_count}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_mode = '0;
    out_ready = 1'b1; rnd_done = 1'b0; cnt_m = 4'd0;
    @(posedge clk); #1;
    do_reset(2);

    // OR of 0x0F and 0xF0, result two cycles after acceptance
    send(32'h0000_F00F, 4'b0011, 3'd0);
    idle();
    @(negedge clk);
    chk("lat_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("or_data", {24'd0, out_data}, 32'h0000_00FF);
    chk("or_any_all", {30'd0, out_any, out_all}, 32'd3);
    @(posedge clk); #1;

    send(32'h00FF_55AA, 4'b0111, 3'd5);
    send(32'h1234_5678, 4'b0000, 3'd4);
    idle();
    @(negedge clk);
    chk("xnor_data", {24'd0, out_data}, 32'h0000_00FF);
    @(negedge clk);
    chk("nand0_data", {24'd0, out_data}, 32'd0);
    chk("nand0_all", {31'd0, out_all}, 32'd0);
    @(posedge clk); #1;

    send(32'hDEAD_BEEF, 4'b1111, 3'd6);
    idle();
    @(negedge clk); @(negedge clk);
    chk("ill_err", {31'd0, out_err}, 32'd1);
    chk("ill_data", {24'd0, out_data}, 32'd0);
    repeat (2) @(posedge clk); #1;

    // Five back-to-back transactions with a backpressure window
    fork
      begin
        for (int i = 0; i < 5; i++) send(32'h0101_0101 * (i + 1), 4'b1111, 3'(i % 6));
        idle();
      end
      begin
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_no_gap", {31'd0, out_valid}, 32'd1);
          @(posedge clk); #1;
        end
      end
    join
    idle();

    // Randomised traffic with random downstream backpressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
          send($urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sbq.size(), 32'd0);

    // Reset with both stages full: neither result may appear afterwards
    out_ready = 1'b0;
    send(32'h0000_0011, 4'b0001, 3'd0);
    send(32'h0000_0022, 4'b0001, 3'd0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_full_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_full_count", {28'd0, out_count}, 32'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Counter wrap: 17 transfers on a 4-bit counter
    do_reset(1);
    for (int i = 0; i < 17; i++) send(32'h0000_0001 << i, 4'b1111, 3'd2);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wrap_count", {28'd0, out_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
